// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM driver: duty width and FSM state encoding.
package pwm_pkg;

  localparam int unsigned DUTY_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StStop = ST_STOP
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler that issues a one-clock count strobe every DIV clocks while running.
//   i_clk  : system clock
//   i_rst  : synchronous reset, active-high
//   i_run  : prescaler counts while high; held at 0 while low
//   o_tick : registered strobe, high one clock after presc reaches DIV-1
module tick_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned DIV = 48
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_tick
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          w_last;

  assign w_last = (r_presc == PW'(DIV - 1));
  assign o_tick = r_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= i_run && w_last;
      if (!i_run || w_last) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_driver_8_bits.sv
// Control and PWM stage around an external 8-bit counter.
// Issues the prescaled count strobe, double-buffers the duty so a new value only takes
// effect at a period wrap, and produces a registered glitch-free PWM output.
//   i_clk          : system clock
//   i_rst          : synchronous reset, active-high
//   i_en           : run request (level)
//   i_duty         : requested duty in counter steps
//   i_duty_wr      : one-clock write strobe for i_duty
//   i_q            : counter value
//   i_ov           : counter wrap flag, high exactly one clock
//   o_cnt          : count-enable strobe to the counter
//   o_pwm          : PWM output
//   o_duty_busy    : a shadow duty is pending and not yet applied
//   o_period_start : one-clock pulse the cycle after each wrap seen in RUN
module pwm_driver_8_bits
  import pwm_pkg::*;
#(
  parameter int unsigned DIV = 48,
  parameter int unsigned M   = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [DUTY_W-1:0] i_duty,
  input  logic              i_duty_wr,
  input  logic [DUTY_W-1:0] i_q,
  input  logic              i_ov,
  output logic              o_cnt,
  output logic              o_pwm,
  output logic              o_duty_busy,
  output logic              o_period_start
);

  if (DIV < 2 || M != (1 << DUTY_W)) begin : g_bad_param
    $error("pwm_driver_8_bits: DIV must be >= 2 and M must equal 2**DUTY_W");
  end

  state_e            r_state;
  state_e            w_state_next;
  logic              w_active;
  logic [DUTY_W-1:0] r_duty_act;
  logic [DUTY_W-1:0] r_duty_sh;
  logic              r_duty_busy;
  logic              r_pwm;
  logic              r_period_start;

  assign w_active = (r_state != StIdle);

  tick_prescaler #(
    .DIV (DIV)
  ) u_tick_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_run  (w_active),
    .o_tick (o_cnt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // STOP lets the current period finish so the counter is parked at 0 whenever IDLE.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (i_en) w_state_next = StRun;
      StRun: begin
        if (!i_en) w_state_next = i_ov ? StIdle : StStop;
      end
      StStop: begin
        if (i_ov) begin
          w_state_next = StIdle;
        end else if (i_en) begin
          w_state_next = StRun;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // In IDLE no period is in flight, so a write applies at once and nothing is left pending.
  // Otherwise the shadow moves to active on the wrap; a write on the wrap clock refills the
  // shadow after the old shadow has been applied.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_duty_act  <= '0;
      r_duty_sh   <= '0;
      r_duty_busy <= 1'b0;
    end else if (r_state == StIdle) begin
      if (i_duty_wr) begin
        r_duty_act  <= i_duty;
        r_duty_sh   <= i_duty;
        r_duty_busy <= 1'b0;
      end
    end else begin
      if (i_ov && r_duty_busy) r_duty_act <= r_duty_sh;
      if (i_duty_wr) begin
        r_duty_sh   <= i_duty;
        r_duty_busy <= 1'b1;
      end else if (i_ov) begin
        r_duty_busy <= 1'b0;
      end
    end
  end

  // q reads 0 during the wrap clock, so the wrap is masked explicitly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_pwm          <= w_active && !i_ov && (i_q < r_duty_act);
      r_period_start <= i_ov && (r_state == StRun);
    end
  end

  assign o_pwm          = r_pwm;
  assign o_duty_busy    = r_duty_busy;
  assign o_period_start = r_period_start;

endmodule

// File: tb/tb_pwm_driver_8_bits.sv
module tb_pwm_driver_8_bits;

  localparam int DIV = 4;
  localparam int M   = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       duty_wr = 1'b0;
  logic [7:0] duty = 8'd0;
  logic [7:0] q;
  logic       ov;
  logic       cnt, pwm, busy, ps;

  always #5 clk = ~clk;

  pwm_driver_8_bits #(
    .DIV (DIV),
    .M   (M)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_en           (en),
    .i_duty         (duty),
    .i_duty_wr      (duty_wr),
    .i_q            (q),
    .i_ov           (ov),
    .o_cnt          (cnt),
    .o_pwm          (pwm),
    .o_duty_busy    (busy),
    .o_period_start (ps)
  );

  // Stand-in for counter_8_bits: steps on cnt, visits qi=M for one clock (q reads 0, ov=1).
  logic [8:0] qi = '0;
  assign q  = qi[7:0];
  assign ov = (qi == 9'(M));

  // Behavioural reference, written from the rules of the block.
  int         m_mode  = 0;  // 0 idle, 1 run, 2 stop
  int         m_since = 0;  // clocks spent outside idle
  logic       m_cnt = 1'b0, m_pwm = 1'b0, m_busy = 1'b0, m_ps = 1'b0;
  logic [7:0] m_act = '0, m_sh = '0;

  always @(posedge clk) begin
    if (rst)        qi <= '0;
    else if (ov)    qi <= '0;
    else if (cnt)   qi <= qi + 9'd1;

    if (rst) begin
      m_mode <= 0; m_since <= 0; m_cnt <= 1'b0; m_pwm <= 1'b0;
      m_busy <= 1'b0; m_ps <= 1'b0; m_act <= '0; m_sh <= '0;
    end else begin
      m_cnt   <= (m_mode != 0) && (m_since % DIV == DIV - 1);
      m_since <= (m_mode != 0) ? m_since + 1 : 0;
      m_pwm   <= (m_mode != 0) && !ov && (int'(q) < int'(m_act));
      m_ps    <= ov && (m_mode == 1);
      case (m_mode)
        0: if (en) m_mode <= 1;
        1: if (!en) m_mode <= ov ? 0 : 2;
        default: if (ov) m_mode <= 0; else if (en) m_mode <= 1;
      endcase
      if (m_mode == 0) begin
        if (duty_wr) begin m_act <= duty; m_sh <= duty; m_busy <= 1'b0; end
      end else begin
        if (ov && m_busy) m_act <= m_sh;
        if (duty_wr) begin m_sh <= duty; m_busy <= 1'b1; end
        else if (ov) m_busy <= 1'b0;
      end
    end
  end

  int n_cmp = 0, n_err = 0;
  int n_ps = 0, hi_acc = 0, len_acc = 0, last_hi = -1, last_len = -1;

  task automatic check(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, got, want);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // One clock: sample on the falling edge, compare to the model, track period statistics.
  task automatic tick();
    @(negedge clk);
    check("cnt", cnt, m_cnt);
    check("pwm", pwm, m_pwm);
    check("duty_busy", busy, m_busy);
    check("period_start", ps, m_ps);
    if (ps) begin
      last_hi = hi_acc; last_len = len_acc;
      hi_acc = int'(pwm); len_acc = 1; n_ps++;
    end else begin
      hi_acc += int'(pwm); len_acc++;
    end
  endtask

  task automatic write_duty(input logic [7:0] v);
    duty = v; duty_wr = 1'b1;
    tick();
    duty_wr = 1'b0;
  endtask

  task automatic wait_ps(input string name);
    int start = n_ps;
    int k = 0;
    while (n_ps == start && k < 3000) begin tick(); k++; end
    if (n_ps == start) timeout(name);
  endtask

  task automatic wait_ov(input string name);
    int k = 0;
    while (!ov && k < 3000) begin tick(); k++; end
    if (!ov) timeout(name);
  endtask

  task automatic wait_q(input int v, input string name);
    int k = 0;
    while (!(int'(q) == v && !ov) && k < 3000) begin tick(); k++; end
    if (int'(q) != v) timeout(name);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    // Reset with en high: everything stays low.
    rst = 1'b1; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_int("rst cnt", int'(cnt), 0);
      check_int("rst pwm", int'(pwm), 0);
      check_int("rst busy", int'(busy), 0);
      check_int("rst ps", int'(ps), 0);
    end
    rst = 1'b0;
    // One clock to enter RUN, then DIV clocks to the first strobe.
    k = 0;
    while (k < 20) begin tick(); k++; if (cnt) break; end
    check_int("first cnt latency", k, 5);
    k = 0;
    while (k < 20) begin tick(); k++; if (cnt) break; end
    check_int("cnt spacing", k, 4);

    // Drop en: period completes, then idle with counter parked.
    en = 1'b0;
    wait_ov("stop to ov");
    tick();
    n = 0;
    for (int i = 0; i < 16; i++) begin tick(); n += int'(cnt); end
    check_int("idle cnt count", n, 0);
    check_int("idle parked q", int'(q), 0);

    // Idle write applies at once; 64 steps -> 4*64-1 high clocks per 1024-clock period.
    write_duty(8'd64);
    check_int("idle write busy", int'(busy), 0);
    en = 1'b1;
    wait_ps("run ps1");
    wait_ps("run ps2");
    check_int("duty64 high", last_hi, 255);
    check_int("period len", last_len, 1024);

    // Mid-period write is buffered until the wrap.
    repeat (100) tick();
    write_duty(8'd200);
    check_int("mid write busy", int'(busy), 1);
    wait_ps("ps after mid write");
    check_int("unchanged width", last_hi, 255);
    check_int("busy cleared at wrap", int'(busy), 0);
    wait_ps("ps duty200");
    check_int("duty200 high", last_hi, 799);

    // Write on the wrap clock: old shadow applies, new value stays pending.
    repeat (100) tick();
    write_duty(8'd50);
    wait_ov("ov for wrap write");
    duty = 8'd10; duty_wr = 1'b1;
    tick();
    duty_wr = 1'b0;
    check_int("wrap write busy", int'(busy), 1);
    check_int("duty200 again", last_hi, 799);
    repeat (500) tick();
    check_int("busy held mid period", int'(busy), 1);
    wait_ps("ps duty50");
    check_int("duty50 high", last_hi, 199);
    check_int("busy after second wrap", int'(busy), 0);
    wait_ps("ps duty10");
    check_int("duty10 high", last_hi, 39);

    // en low at q=100 then back before the wrap: strobes never stop.
    wait_q(100, "q=100");
    en = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin tick(); n += int'(cnt); end
    check_int("stop cnt count", n, 2);
    en = 1'b1;
    wait_ps("ps after restart");
    check_int("restart period len", last_len, 1024);

    // Reset mid-period with a pending duty.
    repeat (200) tick();
    write_duty(8'd128);
    check_int("pending before rst", int'(busy), 1);
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    check_int("post rst busy", int'(busy), 0);
    check_int("post rst pwm", int'(pwm), 0);
    tick();
    check_int("post rst cnt", int'(cnt), 0);

    // Duty extremes.
    write_duty(8'd0);
    en = 1'b1;
    wait_ps("ps duty0 a");
    wait_ps("ps duty0 b");
    check_int("duty0 high", last_hi, 0);
    write_duty(8'd255);
    wait_ps("ps duty255 a");
    wait_ps("ps duty255 b");
    check_int("duty255 high", last_hi, 1019);
    en = 1'b0;
    wait_ov("final ov");
    tick();

    // Randomised run against the model.
    for (int i = 0; i < 30000; i++) begin
      rst = ($urandom_range(0, 4999) == 0);
      if ($urandom_range(0, 599) == 0) en = ~en;
      duty_wr = 1'b0;
      if (ov ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 249) == 0)) begin
        duty_wr = 1'b1;
        case ($urandom_range(0, 3))
          0:       duty = 8'd0;
          1:       duty = 8'hff;
          default: duty = 8'($urandom_range(0, 255));
        endcase
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
